fetch_decode_sequencer: RTL

- Multi-cycle front-end controller for the RV32I core.
- Fetches an instruction word over a variable-latency instruction-memory handshake and latches it.
- Classifies the opcode into an instruction format and builds the sign-extended immediate.
- Presents a registered decode bundle to the execute stage, then waits for the next PC; illegal opcodes and misaligned targets raise a trap.

---
 rtl/fetch_decode_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_decode_sequencer.sv
// RV32I front-end: fetch over a variable-latency handshake, decode format/immediate, issue, await next PC.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_decode_sequencer #(
    parameter int unsigned      XLEN           = 32,
    parameter logic [XLEN-1:0]  RESET_PC       = 32'h0000_0000,
    parameter int unsigned      TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instr,
    output logic [2:0]      dec_format,
    output logic [XLEN-1:0] dec_imm,
    output logic [XLEN-1:0] dec_pc,
    input  logic            npc_valid,
    input  logic [XLEN-1:0] npc,
    output logic            trap,
    output logic [1:0]      trap_cause,
    input  logic            trap_ack
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_NPC, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        F_R = 3'b000, F_I = 3'b001, F_S = 3'b010, F_B = 3'b011,
        F_U = 3'b100, F_J = 3'b101, F_ILLEGAL = 3'b111
    } fmt_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic            dec_valid_q, dec_valid_d;
    logic [31:0]     dec_instr_q, dec_instr_d;
    fmt_t            dec_format_q, dec_format_d;
    logic [XLEN-1:0] dec_imm_q, dec_imm_d;
    logic [XLEN-1:0] dec_pc_q, dec_pc_d;
    logic            trap_q, trap_d;
    logic [1:0]      trap_cause_q, trap_cause_d;
`ifdef FETCH_TIMEOUT_EN
    logic [15:0]     cnt_q, cnt_d;
`endif

    fmt_t            fmt;
    logic [31:0]     imm32;

    // Combinational decode of the latched instruction register.
    always_comb begin
        fmt   = F_ILLEGAL;
        imm32 = '0;
        case (ir_q[6:0])
            7'b0110111, 7'b0010111: fmt = F_U;
            7'b1101111:             fmt = F_J;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011: fmt = F_I;
            7'b1100011:             fmt = F_B;
            7'b0100011:             fmt = F_S;
            7'b0110011:             fmt = F_R;
            default:                fmt = F_ILLEGAL;
        endcase
        case (fmt)
            F_I:     imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
            F_S:     imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            F_B:     imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            F_U:     imm32 = {ir_q[31:12], 12'b0};
            F_J:     imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        dec_valid_d  = dec_valid_q;
        dec_instr_d  = dec_instr_q;
        dec_format_d = dec_format_q;
        dec_imm_d    = dec_imm_q;
        dec_pc_d     = dec_pc_q;
        trap_d       = trap_q;
        trap_cause_d = trap_cause_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d        = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
`ifdef FETCH_TIMEOUT_EN
                // Counter is zero on every FETCH entry because it clears outside FETCH.
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    trap_d       = 1'b1;
                    trap_cause_d = 2'b11;
                    state_d      = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            S_DECODE: begin
                dec_instr_d  = ir_q;
                dec_format_d = fmt;
                dec_imm_d    = XLEN'($signed(imm32));
                dec_pc_d     = pc_q;
                if (fmt == F_ILLEGAL) begin
                    trap_d       = 1'b1;
                    trap_cause_d = 2'b01;
                    state_d      = S_TRAP;
                end else begin
                    dec_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dec_ready) begin
                    dec_valid_d = 1'b0;
                    state_d     = S_WAIT_NPC;
                end
            end
            S_WAIT_NPC: begin
                if (npc_valid) begin
                    if (npc[1:0] != 2'b00) begin
                        trap_d       = 1'b1;
                        trap_cause_d = 2'b10;
                        state_d      = S_TRAP;
                    end else begin
                        pc_d    = npc;
                        state_d = enable ? S_FETCH : S_IDLE;
                    end
                end
            end
            S_TRAP: begin
                if (trap_ack) begin
                    trap_d       = 1'b0;
                    trap_cause_d = 2'b00;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            dec_valid_q  <= 1'b0;
            dec_instr_q  <= '0;
            dec_format_q <= F_R;
            dec_imm_q    <= '0;
            dec_pc_q     <= '0;
            trap_q       <= 1'b0;
            trap_cause_q <= 2'b00;
`ifdef FETCH_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            dec_valid_q  <= dec_valid_d;
            dec_instr_q  <= dec_instr_d;
            dec_format_q <= dec_format_d;
            dec_imm_q    <= dec_imm_d;
            dec_pc_q     <= dec_pc_d;
            trap_q       <= trap_d;
            trap_cause_q <= trap_cause_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    // Request follows the state register so an async reset drops it at once.
    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign dec_valid  = dec_valid_q;
    assign dec_instr  = dec_instr_q;
    assign dec_format = dec_format_q;
    assign dec_imm    = dec_imm_q;
    assign dec_pc     = dec_pc_q;
    assign trap       = trap_q;
    assign trap_cause = trap_cause_q;

endmodule
